// File: rtl/stream_fifo_if.sv
// stream_fifo_if: valid/ready stream bundle carrying one payload beat per handshake.
//   valid  - source offers data
//   ready  - sink accepts; beat transfers when valid & ready
//   data   - payload, DATA_SIZE bits
// Modports: master drives valid/data, slave drives ready.
interface stream_fifo_if #(
  parameter int unsigned DATA_SIZE = 16
) ();
  logic                 valid;
  logic                 ready;
  logic [DATA_SIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised valid/ready FIFO with zero-latency fall-through when empty,
// backpressure or drop-new-on-full behaviour, occupancy/almost-full reporting and a
// clearable sticky overflow flag with saturating drop counter.
// Ports:
//   i_clk          - clock, all state on rising edge
//   i_rst          - synchronous active-high reset
//   s_in           - upstream stream (slave: valid/data in, ready out)
//   m_out          - downstream stream (master: valid/data out, ready in)
//   o_level        - stored entry count, 0..FIFO_DEPTH
//   o_almost_full  - level >= AF_THRESH
//   o_overflow     - sticky, set by any dropped beat
//   i_overflow_clr - clears o_overflow and o_drop_count
//   o_drop_count   - saturating count of dropped beats
module stream_fifo #(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned FIFO_DEPTH = 5,
  parameter bit          DROP_MODE  = 1'b0,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  stream_fifo_if.slave                      s_in,
  stream_fifo_if.master                     m_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_almost_full,
  output logic                              o_overflow,
  input  logic                              i_overflow_clr,
  output logic [DROP_W-1:0]                 o_drop_count
);

  localparam int unsigned    LvlW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned    PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
  localparam logic [LvlW-1:0] LvlAf   = LvlW'(AF_THRESH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_rd;
  logic [PtrW-1:0]      r_wr;
  logic [LvlW-1:0]      r_level;
  logic                 r_almost_full;
  logic                 r_overflow;
  logic [DROP_W-1:0]    r_drop_count;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_bypass;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_push;
  logic [PtrW-1:0]      w_rd_inc;
  logic [PtrW-1:0]      w_wr_inc;
  logic [LvlW-1:0]      w_level_d;
  logic                 w_overflow_d;
  logic [DROP_W-1:0]    w_drop_count_d;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LvlFull);

  // In drop mode the input never stalls; a full FIFO with no pop discards the new beat.
  assign w_in_ready  = DROP_MODE ? !i_rst : (!i_rst & (!w_full | m_out.ready));
  assign w_out_valid = !i_rst & (!w_empty | s_in.valid);

  // Empty FIFO with a willing consumer: the beat goes straight through, nothing is stored.
  assign w_bypass = w_empty & s_in.valid & m_out.ready;
  assign w_pop    = w_out_valid & m_out.ready & !w_empty;
  assign w_drop   = DROP_MODE & !i_rst & s_in.valid & w_full & !m_out.ready;
  assign w_push   = s_in.valid & w_in_ready & !w_bypass & !w_drop;

  assign w_rd_inc = (r_rd == PtrLast) ? '0 : r_rd + PtrW'(1);
  assign w_wr_inc = (r_wr == PtrLast) ? '0 : r_wr + PtrW'(1);

  always_comb begin
    w_level_d = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LvlW'(1);
      2'b01:   w_level_d = r_level - LvlW'(1);
      default: w_level_d = r_level;
    endcase
  end

  // A drop in the same cycle as a clear wins: the new drop is the first one counted.
  always_comb begin
    w_overflow_d   = r_overflow;
    w_drop_count_d = r_drop_count;
    if (w_drop) begin
      w_overflow_d = 1'b1;
      if (i_overflow_clr) begin
        w_drop_count_d = DROP_W'(1);
      end else if (!(&r_drop_count)) begin
        w_drop_count_d = r_drop_count + DROP_W'(1);
      end
    end else if (i_overflow_clr) begin
      w_overflow_d   = 1'b0;
      w_drop_count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd          <= '0;
      r_wr          <= '0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd <= w_rd_inc;
      end
      if (w_push) begin
        r_wr <= w_wr_inc;
      end
      r_level       <= w_level_d;
      r_almost_full <= (w_level_d >= LvlAf);
      r_overflow    <= w_overflow_d;
      r_drop_count  <= w_drop_count_d;
    end
  end

  // Storage is not reset; only entries between rd and wr are ever observed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= s_in.data;
    end
  end

  assign s_in.ready  = w_in_ready;
  assign m_out.valid = w_out_valid;
  assign m_out.data  = w_empty ? s_in.data : r_mem[r_rd];

  assign o_level       = r_level;
  assign o_almost_full = r_almost_full;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised valid/ready stream FIFO; successor to the team's fixed skid buffer. Adds a circular store of arbitrary depth, true backpressure via `in_ready`, a selectable drop-on-full mode, occupancy reporting, an almost-full flag and a clearable overflow/drop counter. Sits between any producer/consumer stage pair in the streaming datapath. Keeps the zero-latency fall-through path when empty.

## Interface

- `DATA_SIZE`, 16, payload width in bits.
- `FIFO_DEPTH`, 5, number of storage entries; any value ≥ 1, power of two not required.
- `DROP_MODE`, 0, 0 = backpressure mode, 1 = drop-new-on-full mode.
- `AF_THRESH`, FIFO_DEPTH-1, `almost_full` asserts when `level` ≥ this value; legal range 1..FIFO_DEPTH.
- `DROP_W`, 8, width of `drop_count`.

- `clk` in 1 — single clock, all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — producer offers `in_data`.
- `in_ready` out 1 — beat accepted when `in_valid & in_ready`.
- `in_data` in DATA_SIZE — producer payload.
- `out_valid` out 1 — head beat available.
- `out_ready` in 1 — consumer takes head when `out_valid & out_ready`.
- `out_data` out DATA_SIZE — head payload.
- `level` out $clog2(FIFO_DEPTH+1) — stored entry count, 0..FIFO_DEPTH.
- `almost_full` out 1 — `level >= AF_THRESH`.
- `overflow` out 1 — sticky; set by any dropped beat (DROP_MODE=1 only).
- `overflow_clr` in 1 — clears `overflow` and `drop_count`.
- `drop_count` out DROP_W — saturating count of dropped beats.

## Operation

- Storage: FIFO_DEPTH-entry array, read pointer `rd`, write pointer `wr`, count `level`. Pointers increment and wrap FIFO_DEPTH-1 → 0. Array contents are not reset.
- `empty = (level == 0)`, `full = (level == FIFO_DEPTH)`.
- `out_valid = !rst & (!empty | in_valid)`; `out_data = empty ? in_data : mem[rd]`.
- `in_ready`: while `rst` = 0. DROP_MODE=0: `!full | out_ready` (pop frees a slot in the same cycle). DROP_MODE=1: constant 1 outside reset.
- Bypass: empty & in_valid & out_ready → beat passes straight through; nothing is stored, `level` stays 0.
- `pop = out_valid & out_ready & !empty` → `rd` advances.
- `push = in_valid & in_ready & !bypass & !drop` → `mem[wr] <= in_data`, `wr` advances.
- `drop` (DROP_MODE=1 only): `in_valid & full & !out_ready`. Beat is discarded, `overflow <= 1`, `drop_count` increments, saturating at all-ones.
- Full & in_valid & out_ready (either mode): simultaneous pop and push; `level` holds at FIFO_DEPTH. No drop occurs.
- `level_next = level + push - pop`. Never exceeds FIFO_DEPTH and never underflows.
- `overflow_clr` and `drop` in the same cycle: set wins, so `overflow` = 1 and `drop_count` = 1.
- `overflow_clr` alone: `overflow` = 0, `drop_count` = 0 next cycle.
- DROP_MODE=0: `overflow` and `drop_count` stay 0 permanently.
- Ordering: beats leave in acceptance order; dropped beats never appear at the output.

## Timing

- Reset: in the cycle after `rst` is sampled high, `level` = 0, `rd` = `wr` = 0, `overflow` = 0, `drop_count` = 0, `almost_full` = 0 (AF_THRESH ≥ 1).
- While `rst` is high: `out_valid` = 0, `in_ready` = 0, no push, pop or drop.
- Reset mid-operation discards all stored beats. The first beat after release may bypass.
- Latency when empty: 0 cycles (combinational fall-through).
- Latency when non-empty: a stored beat reaches the head after all earlier beats pop. A pushed beat is visible at `out_data` no earlier than the next cycle.
- `level`, `almost_full`, `overflow` and `drop_count` are registered state, updated one cycle after the causing handshake. `in_ready` and `out_valid` are combinational.
- Stability: while `out_valid` is high, `!empty` and `out_ready` is low, `out_data` holds across cycles.

## Test plan

- Basic FIFO, DEPTH=5, mode 0: push 0x0001..0x0005 with `out_ready`=0 → `level` = 5, `in_ready` = 0, `almost_full` = 1 from `level` = 4. Then drain → outputs 0x0001..0x0005 in order, `level` = 0.
- Wrap-around: 13 beats interleaved with pops, occupancy held between 2 and 4 → output sequence equals input sequence; pointers wrap at least twice; DEPTH=5 exercises non-power-of-two wrap.
- Bypass: empty, `in_valid` = `out_ready` = 1, `in_data` = 0xBEEF → `out_data` = 0xBEEF in the same cycle, `level` stays 0.
- Full with simultaneous push/pop, both modes: `level` = 5 with `in_valid` = `out_ready` = 1 → `level` stays 5, no drop, head advances.
- Drop mode: full, `out_ready` = 0, 3 beats offered → `overflow` = 1, `drop_count` = 3, contents unchanged. `overflow_clr` together with a 4th drop → `overflow` = 1, `drop_count` = 1. DROP_W=2 with 5 drops → saturates at 3.
- Reset mid-stream: `level` = 3, assert `rst` for 1 cycle → `level` = 0, `out_valid` = 0 during `rst`. After release, 0x00AA bypasses correctly.
